sound_envelope: RTL
===================

Name: sound_envelope

Overview:
- Downstream stage of the sound driver: consumes its raw square-wave `pwm` output and the per-second `sec` tick.
- Shapes each tone with an attack / sustain / release amplitude envelope so that tone changes and mute do not produce audible clicks.
- Amplitude is applied by gating the square wave with a fast carrier PWM whose duty equals the current envelope level.
- Output drives the speaker pin directly.

Parameters:
- TONE_CYCLES, 16000000, clk cycles between `sec` ticks (one tone period at 16 MHz).
- STEP_CYCLES, 1000, clk cycles per envelope level step.
- LEVEL_W, 6, envelope level width. MAX = 2^LEVEL_W - 1.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst  in  1  synchronous, active-high reset.
- sec  in  1  one-cycle tick marking a tone change.
- pwm_in  in  1  raw square wave from the sound driver.
- mute  in  1  level-sensitive. 1 = fade out and stay silent.
- audio_out  out  1  envelope-gated audio, registered.
- level  out  LEVEL_W  current envelope level.
- env_state  out  2  IDLE=0, ATTACK=1, SUSTAIN=2, RELEASE=3.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset (`rst` sampled high at a clk edge):
  - audio_out=0, level=0, env_state=IDLE.
  - carrier_cnt=0, step_cnt=0, tone_cnt=0.
  - Reset overrides every other input, including mid-attack or mid-release.
- Derived constants:
  - RELEASE_CYCLES = MAX*STEP_CYCLES.
  - REL_START = TONE_CYCLES - RELEASE_CYCLES.
- tone_cnt:
  - Cleared to 0 on the edge where `sec`=1.
  - Otherwise increments by 1 per cycle and saturates at TONE_CYCLES-1.
- step_cnt:
  - Cleared to 0 on every state change, and on `sec` when the resulting state is ATTACK.
  - Otherwise counts 0..STEP_CYCLES-1 and wraps to 0.
  - A "step" occurs on a cycle where step_cnt==STEP_CYCLES-1.
- carrier_cnt: free-running LEVEL_W-bit counter, +1 every cycle, wraps MAX->0.
- audio_out: registered every cycle as pwm_in AND (carrier_cnt < level), so latency is 1 cycle.
  - level=0 gives a constant 0.
  - level=MAX gives duty MAX/2^LEVEL_W of pwm_in's high time.
- State machine. Priority within a cycle is rst > sec > mute > step/threshold.
  - IDLE: level held at 0. `sec`=1 with mute=0 -> ATTACK.
  - ATTACK: each step, level+1. On the step where level becomes MAX -> SUSTAIN on the same edge.
    - mute=1 -> RELEASE.
    - tone_cnt >= REL_START -> RELEASE.
  - SUSTAIN: level held at MAX.
    - mute=1 -> RELEASE.
    - tone_cnt == REL_START -> RELEASE.
  - RELEASE: each step, level-1. On the step where level becomes 0 -> IDLE on the same edge.
- `sec` in any state with mute=0:
  - Go to ATTACK, keeping the current level (no jump, no click). Also restarts tone_cnt.
  - If level is already MAX: go to SUSTAIN instead.
- `sec` with mute=1: tone_cnt restarts, but the state does not go to ATTACK. IDLE stays IDLE; any other state goes to or stays in RELEASE.
- mute deasserted during RELEASE: release continues. A new attack starts only at the next `sec`.
- level never wraps: it is clamped to 0..MAX in all states.

Test Plan:
Bench parameters: TONE_CYCLES=400, STEP_CYCLES=4, LEVEL_W=3 (MAX=7, REL_START=372). pwm_in held 1 unless noted.

1. Reset, then a single `sec` pulse at edge t0:
   - env_state=ATTACK after t0.
   - level=1 after t0+4.
   - level=7 and env_state=SUSTAIN after t0+28.
2. Continue scenario 1 with no further `sec`:
   - RELEASE entered at the edge after tone_cnt=372.
   - level decrements once per 4 cycles.
   - Reaches 0 and IDLE 28 cycles later. audio_out constant 0 thereafter.
3. Duty check at level=7 with pwm_in=1: over any 8 consecutive cycles audio_out is high exactly 7 times. At level=3, exactly 3 times. With pwm_in=0, audio_out is always 0.
4. Assert mute during SUSTAIN:
   - RELEASE entered on the next edge; level 7->0 in 28 cycles.
   - A following `sec` with mute still 1 leaves env_state=IDLE and level=0.
5. Early `sec` during RELEASE at level=4: env_state=ATTACK on the next edge with level still 4; level=7 after 12 further cycles.
6. `rst` high for one cycle during ATTACK at level=3: all outputs 0 and env_state=IDLE after that edge. Next `sec` restarts the attack from level 0.

Source files
------------

// File: rtl/sound_envelope.sv
// Attack / sustain / release envelope for the sound driver's square wave.
// The raw tone is gated by a fast carrier PWM whose duty tracks the envelope
// level, so tone changes and mute ramp smoothly instead of clicking.
module sound_envelope #(
    parameter int unsigned TONE_CYCLES = 16000000,
    parameter int unsigned STEP_CYCLES = 1000,
    parameter int unsigned LEVEL_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sec,
    input  logic               pwm_in,
    input  logic               mute,
    output logic               audio_out,
    output logic [LEVEL_W-1:0] level,
    output logic [1:0]         env_state
);

    localparam int unsigned MAX            = (1 << LEVEL_W) - 1;
    localparam int unsigned RELEASE_CYCLES = MAX * STEP_CYCLES;
    localparam int unsigned REL_START      = TONE_CYCLES - RELEASE_CYCLES;
    localparam int unsigned TONE_W         = (TONE_CYCLES > 1) ? $clog2(TONE_CYCLES) : 1;
    localparam int unsigned STEP_W         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_CYCLES - 1);
    localparam logic [TONE_W-1:0]  TONE_ONE   = TONE_W'(1);
    localparam logic [TONE_W-1:0]  REL_AT     = TONE_W'(REL_START);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state;
    logic [TONE_W-1:0]   tone_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [LEVEL_W-1:0]  carrier_cnt;
    logic                step_hit;
    logic [STEP_W-1:0]   step_nxt;

    assign env_state = state;
    assign step_hit  = (step_cnt == STEP_LAST);
    assign step_nxt  = step_hit ? '0 : step_cnt + STEP_ONE;

    // Position within the current tone; restarts on every tone tick, saturates at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt <= '0;
        end else if (sec) begin
            tone_cnt <= '0;
        end else if (tone_cnt != TONE_LAST) begin
            tone_cnt <= tone_cnt + TONE_ONE;
        end
    end

    // Free-running carrier; its natural wrap gives the PWM period of 2^LEVEL_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_cnt <= '0;
        end else begin
            carrier_cnt <= carrier_cnt + LEVEL_ONE;
        end
    end

    // Gate the raw square wave with the carrier PWM at the current level.
    always_ff @(posedge clk) begin
        if (rst) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= pwm_in & (carrier_cnt < level);
        end
    end

    // Envelope FSM: owns state, level and the step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            level    <= '0;
            step_cnt <= '0;
        end else if (sec && !mute) begin
            // New tone: ramp from wherever the level is now, never jump.
            if (level == LEVEL_MAX) begin
                state    <= SUSTAIN;
                step_cnt <= (state == SUSTAIN) ? step_nxt : '0;
            end else begin
                state    <= ATTACK;
                step_cnt <= '0;
            end
        end else if (sec && (state == ATTACK || state == SUSTAIN)) begin
            // Muted tone tick: fade out rather than start a new attack.
            state    <= RELEASE;
            step_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    level    <= '0;
                    step_cnt <= step_nxt;
                end
                ATTACK: begin
                    if (mute || tone_cnt >= REL_AT) begin
                        state    <= RELEASE;
                        step_cnt <= '0;
                    end else if (level == LEVEL_MAX) begin
                        state    <= SUSTAIN;
                        step_cnt <= '0;
                    end else if (step_hit) begin
                        level <= level + LEVEL_ONE;
                        if (level == LEVEL_MAX - LEVEL_ONE) begin
                            state    <= SUSTAIN;
                            step_cnt <= '0;
                        end else begin
                            step_cnt <= step_nxt;
                        end
                    end else begin
                        step_cnt <= step_nxt;
                    end
                end
                SUSTAIN: begin
                    level <= LEVEL_MAX;
                    if (mute || tone_cnt == REL_AT) begin
                        state    <= RELEASE;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_nxt;
                    end
                end
                RELEASE: begin
                    // Level 0 can be reached here if release began mid-attack at 0.
                    if (level == '0) begin
                        state    <= IDLE;
                        step_cnt <= '0;
                    end else if (step_hit) begin
                        level <= level - LEVEL_ONE;
                        if (level == LEVEL_ONE) begin
                            state    <= IDLE;
                            step_cnt <= '0;
                        end else begin
                            step_cnt <= step_nxt;
                        end
                    end else begin
                        step_cnt <= step_nxt;
                    end
                end
                default: begin
                    state    <= IDLE;
                    level    <= '0;
                    step_cnt <= '0;
                end
            endcase
        end
    end

endmodule
